// File: rtl/prbs_pkg.sv
// Shared types and widths for the PRBS sequencer and its delay line.
package prbs_pkg;
   localparam int SEED_W = 32;
   localparam int N_W    = 8;
   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/prbs_ctrl_dly.sv
// DEPTH-stage valid/last shift line; aligns issued bytes with generator output.
module prbs_ctrl_dly #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_flush,
   input  logic i_valid,
   input  logic i_last,
   output logic o_valid,
   output logic o_last
);
   logic [DEPTH-1:0] r_vld_pipe;
   logic [DEPTH-1:0] r_last_pipe;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
      end else if (i_flush) begin
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
      end else begin
         r_vld_pipe[0]  <= i_valid;
         r_last_pipe[0] <= i_valid & i_last;
         for (int i = 1; i < DEPTH; i++) begin
            r_vld_pipe[i]  <= r_vld_pipe[i-1];
            r_last_pipe[i] <= r_last_pipe[i-1];
         end
      end
   end

   assign o_valid = r_vld_pipe[DEPTH-1];
   assign o_last  = r_last_pipe[DEPTH-1];
endmodule

// File: rtl/prbs_ctrl.sv
// PRBS generator sequencer: load, gated run, framed byte forwarding, done pulse.
// Optional PRBS_CTRL_SIG_EN adds sig = XOR of all bytes emitted in the current run.
module prbs_ctrl
   import prbs_pkg::*;
#(
   parameter int LEN_W   = 16,
   parameter int GEN_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              ready,
   input  logic [SEED_W-1:0] cfg_seed,
   input  logic [N_W-1:0]    cfg_n,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              hold,
   input  logic              abort,
   output logic              prbs_rst,
   output logic [SEED_W-1:0] prbs_in,
   output logic [N_W-1:0]    prbs_n,
   output logic              prbs_data_valid,
   input  logic [BYTE_W-1:0] prbs_out,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   output logic              done,
`ifdef PRBS_CTRL_SIG_EN
   output logic [BYTE_W-1:0] sig,
`endif
   output logic              busy
);
   state_t              r_state;
   logic [SEED_W-1:0]   r_seed;
   logic [N_W-1:0]      r_n;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_issue;
   logic [BYTE_W-1:0]   r_out_data;
   logic                r_out_valid;
   logic                r_out_last;
   logic                w_last_issue;
   logic                w_tap_valid;
   logic                w_tap_last;

   assign ready           = (r_state == IDLE);
   assign busy            = (r_state != IDLE);
   assign done            = (r_state == DONE);
   assign prbs_rst        = (r_state == IDLE) || (r_state == LOAD);
   assign prbs_in         = r_seed;
   assign prbs_n          = r_n;
   assign prbs_data_valid = (r_state == RUN) && !hold;
   // r_issue < r_len in RUN, so the increment below cannot wrap
   assign w_last_issue    = prbs_data_valid && ((r_issue + LEN_W'(1)) == r_len);
   assign out_data        = r_out_data;
   assign out_valid       = r_out_valid;
   assign out_last        = r_out_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_seed  <= '0;
         r_n     <= '0;
         r_len   <= '0;
         r_issue <= '0;
      end else if (abort) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_seed  <= cfg_seed;
               r_n     <= cfg_n;
               r_len   <= cfg_len;
               r_state <= LOAD;
            end
            LOAD: begin
               r_issue <= '0;
               r_state <= (r_len != '0) ? RUN : DONE;
            end
            RUN: if (prbs_data_valid) begin
               r_issue <= r_issue + LEN_W'(1);
               if (w_last_issue) r_state <= DRAIN;
            end
            // out_last visible this cycle means the line is empty behind it
            DRAIN: if (r_out_valid && r_out_last) r_state <= DONE;
            DONE:  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   prbs_ctrl_dly #(.DEPTH(GEN_LAT)) u_dly (
      .clk     (clk),
      .rst     (rst),
      .i_flush (abort),
      .i_valid (prbs_data_valid),
      .i_last  (w_last_issue),
      .o_valid (w_tap_valid),
      .o_last  (w_tap_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (abort) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         r_out_valid <= w_tap_valid;
         r_out_last  <= w_tap_valid & w_tap_last;
         if (w_tap_valid) r_out_data <= prbs_out;
      end
   end

`ifdef PRBS_CTRL_SIG_EN
   logic [BYTE_W-1:0] r_sig;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           r_sig <= '0;
      else if (r_state == LOAD)           r_sig <= '0;
      else if (w_tap_valid && !abort)     r_sig <= r_sig ^ prbs_out;
   end

   assign sig = r_sig;
`endif
endmodule
